wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the single-cycle ALU writeback path (requester A) and the multi-cycle load/multiply unit (requester B).
- Drives the select of the 64-bit writeback-data 2-way mux and the 5-bit write-register 2-way mux.
- Buffers one B result, gives A priority, and bounds B starvation by stalling the pipeline for one cycle.

Parameters:
- DATA_W, 64, writeback data width
- REG_W, 5, register index width
- MAX_WAIT, 4, consecutive A wins tolerated while B is held before a forced B grant (legal range 1..7)
- ZERO_REG, 31, register index whose writes are suppressed (XZR)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- aValid  in  1  A writeback request this cycle; no backpressure
- aReg  in  REG_W  A destination register
- aData  in  DATA_W  A result
- bValid  in  1  B result valid
- bReady  out  1  B result accepted when bValid && bReady
- bReg  in  REG_W  B destination register
- bData  in  DATA_W  B result
- stallA  out  1  freeze A pipeline; upstream holds aValid/aReg/aData stable
- wbSel  out  1  registered mux select: 0 = A path, 1 = B path
- wbEn  out  1  registered register-file write enable
- wbReg  out  REG_W  registered write register
- wbData  out  DATA_W  registered write data

Behaviour:
- Reset, asynchronous, rst_n low:
  - state = IDLE, hold register empty, wait counter = 0.
  - wbEn, wbSel, wbReg, wbData = 0; stallA = 0.
  - bReady goes to 1 after reset is released.
  - Reset mid-operation discards any held B result.
- Hold register: one entry (holdReg, holdData).
  - bReady = (state == IDLE), combinational from state.
  - An accepted B result is captured at the clock edge.
- Grant decided combinationally each cycle. Winner's reg/data/source are registered into wbReg/wbData/wbSel; latency is 1 cycle from grant to wbEn.
- wbEn = 1 for a granted write unless the granted register == ZERO_REG. A suppressed write still consumes the grant: the hold is freed and A is retired.
- No grant in a cycle: wbEn = 0 next cycle; wbReg/wbData/wbSel keep their previous values.
- IDLE:
  - aValid → grant A.
  - bValid is accepted in the same cycle if present: capture it → WAIT, counter = 0.
  - A captured B is never granted in its capture cycle.
- WAIT:
  - aValid = 0 → grant hold, empty it → IDLE.
  - aValid = 1 → grant A, counter += 1. If counter reaches MAX_WAIT → FORCE.
- FORCE:
  - stallA = 1 (decoded from state); grant hold regardless of aValid.
  - Counter = 0 → IDLE.
  - The stalled A request is granted in a following cycle.
- B is never held more than MAX_WAIT+1 cycles after capture.
- Write ordering: A and B never target the same register concurrently. Hazard detection upstream guarantees this; no ordering check here.

Test Plan:
- A-only stream, aValid=1 for 3 cycles with regs 1,2,3, data 0x11,0x22,0x33 → wbEn=1, wbSel=0 one cycle later for each, matching reg/data; bReady stays 1.
- B alone, bValid=1, bReg=5, bData=0xDEADBEEF, aValid=0 → captured in cycle 0, bReady=0 in cycle 1; wbEn=1, wbSel=1, wbReg=5 in cycle 2; bReady=1 in cycle 2.
- B captured, then A valid continuously (MAX_WAIT=4) → four A writes; then stallA=1 for exactly one cycle with the B write granted; the stalled A write follows; no A write lost or duplicated.
- A to reg 31, and separately B to reg 31 → wbEn stays 0; the B hold frees (bReady back to 1); wait counter resets.
- Simultaneous aValid and bValid in IDLE → A written next cycle, B held; B written the first cycle aValid=0.
- rst_n pulsed low asynchronously while in WAIT with B held → all outputs 0 immediately, held B never written, bReady=1 after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between two requesters:
//   A - single-cycle ALU writeback. It has priority and no backpressure.
//   B - multi-cycle load/multiply unit. One result is buffered in a hold register.
// B can be held for at most MAX_WAIT consecutive A wins. After that the
// arbiter stalls the A pipeline for one cycle and writes the held B result.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   aValid/aReg/aData    A writeback request (held stable by upstream while stallA=1)
//   bValid/bReady        B result handshake (accepted when both are high)
//   bReg/bData           B result
//   stallA               freeze the A pipeline for one cycle
//   wbSel                registered mux select, 0 = A path, 1 = B path
//   wbEn/wbReg/wbData    registered register-file write port
module wb_port_arbiter #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 4,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aValid,
  input  logic [REG_W-1:0]  aReg,
  input  logic [DATA_W-1:0] aData,
  input  logic              bValid,
  output logic              bReady,
  input  logic [REG_W-1:0]  bReg,
  input  logic [DATA_W-1:0] bData,
  output logic              stallA,
  output logic              wbSel,
  output logic              wbEn,
  output logic [REG_W-1:0]  wbReg,
  output logic [DATA_W-1:0] wbData
);

  // IDLE means the hold register is empty. WAIT and FORCE both mean it is occupied.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [2:0]       MAX_CNT  = 3'(MAX_WAIT);
  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          cnt_inc;
  logic [REG_W-1:0]    hold_reg_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic                capture;
  logic                grant_a, grant_b;
  logic [REG_W-1:0]    grant_reg;
  logic [DATA_W-1:0]   grant_data;

  assign bReady  = (state_q == IDLE);
  assign stallA  = (state_q == FORCE);
  assign cnt_inc = cnt_q + 3'd1;

  // Next-state and grant decision. A result captured in IDLE is not granted
  // in the same cycle: the grant in IDLE can only go to A.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        grant_a = aValid;
        if (bValid) begin
          capture = 1'b1;
          state_d = WAIT;
          cnt_d   = 3'd0;
        end
      end
      WAIT: begin
        if (!aValid) begin
          grant_b = 1'b1;
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          grant_a = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == MAX_CNT) begin
            state_d = FORCE;
          end
        end
      end
      FORCE: begin
        // A is frozen upstream, so it re-presents the same request next cycle.
        grant_b = 1'b1;
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign grant_reg  = grant_b ? hold_reg_q  : aReg;
  assign grant_data = grant_b ? hold_data_q : aData;

  // State and wait counter. Reset discards any held B result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold register. It is loaded only when a B result is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg_q  <= '0;
      hold_data_q <= '0;
    end else if (capture) begin
      hold_reg_q  <= bReg;
      hold_data_q <= bData;
    end
  end

  // Registered write port. A grant to the zero register still updates
  // reg/data/select but leaves the write enable low. With no grant, only
  // the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbEn   <= 1'b0;
      wbSel  <= 1'b0;
      wbReg  <= '0;
      wbData <= '0;
    end else if (grant_a || grant_b) begin
      wbEn   <= (grant_reg != ZERO_IDX);
      wbSel  <= grant_b;
      wbReg  <= grant_reg;
      wbData <= grant_data;
    end else begin
      wbEn   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Directed scenarios and randomized traffic for wb_port_arbiter. The reference
// model describes the held B result as an occupied slot with a count of A wins.
// The slot is drained when A is idle or when the count reaches MAX_WAIT.
module tb_wb_port_arbiter;

  localparam int DATA_W   = 64;
  localparam int REG_W    = 5;
  localparam int MAX_WAIT = 4;
  localparam int ZERO_REG = 31;

  logic              clk;
  logic              rst_n;
  logic              aValid;
  logic [REG_W-1:0]  aReg;
  logic [DATA_W-1:0] aData;
  logic              bValid;
  logic              bReady;
  logic [REG_W-1:0]  bReg;
  logic [DATA_W-1:0] bData;
  logic              stallA;
  logic              wbSel;
  logic              wbEn;
  logic [REG_W-1:0]  wbReg;
  logic [DATA_W-1:0] wbData;

  int testCount;
  int failCount;

  // Reference model state.
  logic              mHeld;
  logic [REG_W-1:0]  mHoldReg;
  logic [DATA_W-1:0] mHoldData;
  int                mWins;
  logic              mEn;
  logic              mSel;
  logic [REG_W-1:0]  mReg;
  logic [DATA_W-1:0] mData;
  logic              bAccepted;

  wb_port_arbiter #(
    .DATA_W  (DATA_W),
    .REG_W   (REG_W),
    .MAX_WAIT(MAX_WAIT),
    .ZERO_REG(ZERO_REG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .aValid(aValid),
    .aReg  (aReg),
    .aData (aData),
    .bValid(bValid),
    .bReady(bReady),
    .bReg  (bReg),
    .bData (bData),
    .stallA(stallA),
    .wbSel (wbSel),
    .wbEn  (wbEn),
    .wbReg (wbReg),
    .wbData(wbData)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. Every check is counted, and a mismatch is reported.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The model stalls A once the held result has lost MAX_WAIT times.
  function automatic logic modelStall();
    return mHeld && (mWins == MAX_WAIT);
  endfunction

  task automatic modelReset();
    mHeld     = 1'b0;
    mHoldReg  = '0;
    mHoldData = '0;
    mWins     = 0;
    mEn       = 1'b0;
    mSel      = 1'b0;
    mReg      = '0;
    mData     = '0;
    bAccepted = 1'b0;
  endtask

  // Drives one cycle of inputs and checks bReady/stallA before the edge.
  // It then advances the model, crosses the edge, and checks the write port.
  // Entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic av, input logic [REG_W-1:0] ar, input logic [DATA_W-1:0] ad,
                               input logic bv, input logic [REG_W-1:0] br, input logic [DATA_W-1:0] bd);
    logic heldBefore;
    logic stall;
    logic granted;
    logic gSel;
    logic [REG_W-1:0] gReg;
    logic [DATA_W-1:0] gData;
    aValid = av; aReg = ar; aData = ad;
    bValid = bv; bReg = br; bData = bd;
    #1;
    heldBefore = mHeld;
    stall      = modelStall();
    checkOutput("bReady", {63'd0, bReady}, {63'd0, !heldBefore});
    checkOutput("stallA", {63'd0, stallA}, {63'd0, stall});
    granted = 1'b0; gSel = 1'b0; gReg = '0; gData = '0;
    if (heldBefore && (stall || !av)) begin
      granted = 1'b1; gSel = 1'b1; gReg = mHoldReg; gData = mHoldData;
      mHeld = 1'b0;
      mWins = 0;
    end else if (av) begin
      granted = 1'b1; gSel = 1'b0; gReg = ar; gData = ad;
      if (heldBefore) mWins++;
    end
    bAccepted = bv && !heldBefore;
    if (bAccepted) begin
      mHeld = 1'b1; mHoldReg = br; mHoldData = bd; mWins = 0;
    end
    if (granted) begin
      mEn = (gReg != REG_W'(ZERO_REG));
      mSel = gSel; mReg = gReg; mData = gData;
    end else begin
      mEn = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("wbEn", {63'd0, wbEn}, {63'd0, mEn});
    checkOutput("wbSel", {63'd0, wbSel}, {63'd0, mSel});
    checkOutput("wbReg", {59'd0, wbReg}, {59'd0, mReg});
    checkOutput("wbData", wbData, mData);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Asserts reset between clock edges and checks that the outputs clear
  // immediately, before any edge. Releases reset on a falling edge.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    aValid = 1'b0; aReg = '0; aData = '0;
    bValid = 1'b0; bReg = '0; bData = '0;
    #1;
    checkOutput("rstWbEn", {63'd0, wbEn}, 64'd0);
    checkOutput("rstWbSel", {63'd0, wbSel}, 64'd0);
    checkOutput("rstWbReg", {59'd0, wbReg}, 64'd0);
    checkOutput("rstWbData", wbData, 64'd0);
    checkOutput("rstStallA", {63'd0, stallA}, 64'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postRstBReady", {63'd0, bReady}, 64'd1);
  endtask

  initial begin
    int stallSeen;
    int aWrites;
    logic [REG_W-1:0]  curAReg;
    logic [DATA_W-1:0] curAData;
    logic              curAValid;
    logic              rbV;
    logic [REG_W-1:0]  rbR;
    logic [DATA_W-1:0] rbD;

    testCount = 0;
    failCount = 0;
    modelReset();
    rst_n = 1'b0;
    aValid = 1'b0; aReg = '0; aData = '0;
    bValid = 1'b0; bReg = '0; bData = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("initWbEn", {63'd0, wbEn}, 64'd0);
    checkOutput("initWbData", wbData, 64'd0);
    checkOutput("initStallA", {63'd0, stallA}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("initBReady", {63'd0, bReady}, 64'd1);

    // A-only stream.
    applyStimulus(1'b1, 5'd1, 64'h11, 1'b0, '0, '0);
    checkOutput("aStream1Reg", {59'd0, wbReg}, 64'd1);
    applyStimulus(1'b1, 5'd2, 64'h22, 1'b0, '0, '0);
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b0, '0, '0);
    checkOutput("aStream3Data", wbData, 64'h33);
    idleCycle();

    // B alone.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd5, 64'hDEADBEEF);
    checkOutput("bAloneNotReady", {63'd0, bReady}, 64'd0);
    idleCycle();
    checkOutput("bAloneWbReg", {59'd0, wbReg}, 64'd5);
    checkOutput("bAloneWbSel", {63'd0, wbSel}, 64'd1);
    idleCycle();

    // B captured, then A valid continuously. A is frozen for the single stall cycle.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 64'hB7B7);
    stallSeen = 0;
    aWrites = 0;
    curAReg = 5'd9;
    curAData = 64'hA0;
    for (int i = 0; i < 7; i++) begin
      if (!modelStall()) begin
        curAReg = curAReg + 5'd1;
        curAData = curAData + 64'h1;
      end
      applyStimulus(1'b1, curAReg, curAData, 1'b0, '0, '0);
      if (stallA) stallSeen++;
      if (wbEn && !wbSel) aWrites++;
    end
    checkOutput("forceStallCount", 64'(stallSeen), 64'd1);
    checkOutput("forceAWrites", 64'(aWrites), 64'd6);
    idleCycle();

    // Writes to the zero register are suppressed but still consume the grant.
    applyStimulus(1'b1, 5'd31, 64'h3131, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd31, 64'hB31);
    idleCycle();
    idleCycle();

    // Simultaneous A and B in IDLE. B drains on the first cycle without A.
    applyStimulus(1'b1, 5'd4, 64'h44, 1'b1, 5'd6, 64'h66);
    applyStimulus(1'b1, 5'd8, 64'h88, 1'b0, '0, '0);
    idleCycle();
    idleCycle();

    // Reset while B is held in WAIT. The held result is never written.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd12, 64'hC0C0);
    applyStimulus(1'b1, 5'd10, 64'hAA, 1'b0, '0, '0);
    doReset();
    idleCycle();
    idleCycle();

    // Randomized traffic. A is frozen while stalled, and B holds until accepted.
    curAValid = 1'b0; curAReg = '0; curAData = '0;
    rbV = 1'b0; rbR = '0; rbD = '0;
    for (int i = 0; i < 400; i++) begin
      if (!modelStall()) begin
        curAValid = ($urandom_range(0, 99) < 60);
        curAReg = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        curAData = {$urandom, $urandom};
      end
      if (!rbV || bAccepted) begin
        rbV = ($urandom_range(0, 99) < 35);
        rbR = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        rbD = {$urandom, $urandom};
      end
      applyStimulus(curAValid, curAReg, curAData, rbV, rbR, rbD);
      if (i == 200) begin
        doReset();
        rbV = 1'b0;
        curAValid = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
